fetch_queue: RTL and testbench

Instruction fetch queue between the IFU (PC register + instruction ROM) and the decode stage. It buffers {PC, instruction} pairs produced each cycle by the IFU, decouples fetch from decode stalls with a valid/ready handshake, and discards all buffered work on a control-flow redirect (flush). When the queue is full, the IFU holds its PC through `in_ready`.

---
 rtl/fetch_queue_if.sv | 32 +++
 rtl/fetch_queue.sv | 95 +++++++++
 tb/tb_fetch_queue.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_if
// Brief    : Handshake bundle between the IFU, the fetch queue and decode.
//            master = IFU/decode side, slave = the queue itself.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_queue_if #(
  parameter int CNT_W = 3
) ();
  logic             in_valid;
  logic [31:0]      in_pc;
  logic [31:0]      in_instr;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_pc;
  logic [31:0]      out_instr;
  logic             out_ready;
  logic             flush;
  logic [CNT_W-1:0] count;

  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_instr, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instr, count
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Circular {PC, instruction} buffer between fetch and decode with
//            valid/ready handshake and single-cycle flush on redirect.
//            Optional same-cycle bypass on an empty queue is enabled by
//            defining FETCH_QUEUE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  wire logic    clk,
  input  wire logic    rst,
  fetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0]    C_PTR_ONE = PW'(1);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  logic [63:0]      mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, full, bypass, push, pop;
  logic [63:0]      head;

  // Handshake, push/pop qualification and head-of-queue output mux
  always_comb begin
    // Pointers carry one extra wrap bit: equal means empty, equal index with
    // differing wrap bit means full. Equivalent to count==0 / count==DEPTH.
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass = empty && bus.in_valid && !bus.flush;
`else
    bypass = 1'b0;
`endif
    bus.in_ready  = !full;
    bus.out_valid = !empty || bypass;
    // A bypassed pair taken by decode this cycle is never stored.
    push = bus.in_valid && !full && !bus.flush && !(bypass && bus.out_ready);
    pop  = !empty && bus.out_ready && !bus.flush;
    head = '0;
    if (bypass) begin
      head = {bus.in_pc, bus.in_instr};
    end else if (!empty) begin
      head = mem_q[rd_ptr_q[AW-1:0]];
    end
    bus.out_pc    = head[63:32];
    bus.out_instr = head[31:0];
    bus.count     = count_q;
  end

  // Next pointer/count: flush dominates, then independent push and pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + C_PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + C_CNT_ONE;
        2'b01:   count_d = count_q - C_CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage array: written on push only, contents survive reset and flush
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {bus.in_pc, bus.in_instr};
  end

  // Pointer and occupancy registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Brief    : Directed self-checking bench for fetch_queue (DEPTH 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  fetch_queue_if #(.CNT_W(3)) bus ();

  fetch_queue #(.DEPTH(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_pc    = pc;
    bus.in_instr = instr_of(pc);
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  int          n_seen;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    drive(1'b0, 32'h0);

    // Reset state
    #2;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_pc", bus.out_pc, 32'h0);
    #10 rst = 1'b1;

    // Store two entries, then assert reset asynchronously mid-cycle
    tick();
    drive(1'b1, 32'h3000);
    tick();
    drive(1'b1, 32'h3004);
    tick();
    drive(1'b0, 32'h0);
    check("two_stored_count", 32'(bus.count), 32'd2);
    #2 rst = 1'b0;
    #1;
    check("async_rst_count", 32'(bus.count), 32'd0);
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("async_rst_out_pc", bus.out_pc, 32'h0);
    check("async_rst_out_instr", bus.out_instr, 32'h0);
    #1 rst = 1'b1;
    drive(1'b1, 32'h3000);
    tick();
    drive(1'b0, 32'h0);
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd1);
    check("post_rst_out_pc", bus.out_pc, 32'h3000);
    check("post_rst_count", 32'(bus.count), 32'd1);

    // Empty via flush
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_empty_count", 32'(bus.count), 32'd0);

    // Fill with decode stalled
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h3000 + 32'(4 * i));
      tick();
    end
    check("full_count", 32'(bus.count), 32'd4);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 32'h3010);
    tick();
    check("refused_count", 32'(bus.count), 32'd4);
    check("refused_head_pc", bus.out_pc, 32'h3000);
    check("refused_head_instr", bus.out_instr, instr_of(32'h3000));

    // Full with simultaneous pop: pop only, no push
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0);
    check("fullpop_count", 32'(bus.count), 32'd3);
    check("fullpop_in_ready", 32'(bus.in_ready), 32'd1);
    check("fullpop_head_pc", bus.out_pc, 32'h3004);

    // Flush with 3 held, colliding with a push and a pop
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h3020);
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 32'h0);
    check("flush_count", 32'(bus.count), 32'd0);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    check("flush_out_pc", bus.out_pc, 32'h0);
    tick();
    check("flush_no_ghost_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h3024);
    tick();
    drive(1'b0, 32'h0);
    check("after_flush_out_valid", 32'(bus.out_valid), 32'd1);
    check("after_flush_out_pc", bus.out_pc, 32'h3024);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;

    // Streaming with decode always ready; pointers wrap several times
    bus.out_ready = 1'b1;
    n_seen = 0;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) drive(1'b1, 32'h3000 + 32'(4 * i));
      else        drive(1'b0, 32'h0);
      #1;
      if (bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_pc);
      if (bus.out_valid) begin
        exp_pc = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check("stream_pc", bus.out_pc, exp_pc);
        check("stream_instr", bus.out_instr, instr_of(exp_pc));
        n_seen++;
      end
      check("stream_count_le1", 32'(bus.count <= 3'd1), 32'd1);
      tick();
    end
    check("stream_all_seen", 32'(n_seen), 32'd16);
    check("stream_end_count", 32'(bus.count), 32'd0);

    // Empty-queue latency with decode ready
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h3000);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    check("byp_same_valid", 32'(bus.out_valid), 32'd1);
    check("byp_same_pc", bus.out_pc, 32'h3000);
    tick();
    drive(1'b0, 32'h0);
    check("byp_count", 32'(bus.count), 32'd0);
    check("byp_next_valid", 32'(bus.out_valid), 32'd0);
`else
    check("nobyp_same_valid", 32'(bus.out_valid), 32'd0);
    tick();
    drive(1'b0, 32'h0);
    check("nobyp_next_valid", 32'(bus.out_valid), 32'd1);
    check("nobyp_next_pc", bus.out_pc, 32'h3000);
    tick();
    check("nobyp_drained_count", 32'(bus.count), 32'd0);
`endif
    bus.out_ready = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
